// File: rtl/vending_txn_ctrl.sv
// vending_txn_ctrl: transaction controller for the vending machine datapath.
// Decodes coin / item / return events, computes the next credit total for the
// downstream total register, runs the inactivity timer and the greedy
// change-return machine, and registers the dispense and coin-return pulses.
module vending_txn_ctrl #(
  parameter  int kTotalBits = 31,
  parameter  int kWaitTime  = 10,
  localparam int kNumCoins  = 3,
  localparam int kNumItems  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kTotalBits-1:0] current_total_nxt,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kNumCoins-1:0]  o_return_coin
);

  // Coin values and item prices, both ordered ascending by index; the greedy
  // return search relies on that ordering.
  localparam int unsigned kCoinValue [kNumCoins] = '{100, 500, 1000};
  localparam int unsigned kItemPrice [kNumItems] = '{400, 500, 1000, 2000};

  localparam int kTimerBits = $clog2(kWaitTime + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  state_e                  state_q, state_nxt;
  logic [kTimerBits-1:0]   timer_q, timer_nxt;
  logic [kNumItems-1:0]    output_item_nxt;
  logic [kNumCoins-1:0]    return_coin_nxt;

  logic                    coin_valid, item_valid, item_affordable, coin_overflow;
  logic                    reload;
  logic [kTotalBits-1:0]   coin_value, item_price, ret_value;
  logic [kTotalBits:0]     coin_sum;
  logic [kNumCoins-1:0]    ret_onehot;

  // Decode coin/item value and pick the largest coin that fits the credit.
  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    coin_valid = $onehot(i_input_coin);
    item_valid = $onehot(i_select_item);
    coin_value = '0;
    item_price = '0;
    ret_value  = '0;
    ret_onehot = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i]) coin_value = kTotalBits'(kCoinValue[i]);
    end
    for (int i = 0; i < kNumItems; i++) begin
      if (i_select_item[i]) item_price = kTotalBits'(kItemPrice[i]);
    end
    // Ascending scan: the last coin that fits is the largest one.
    for (int i = 0; i < kNumCoins; i++) begin
      if (current_total >= kTotalBits'(kCoinValue[i])) begin
        ret_onehot    = '0;
        ret_onehot[i] = 1'b1;
        ret_value     = kTotalBits'(kCoinValue[i]);
      end
    end
    coin_sum        = {1'b0, current_total} + {1'b0, coin_value};
    coin_overflow   = coin_sum[kTotalBits];
    item_affordable = current_total >= item_price;
  end

  // Affordability flags, suppressed while change is being returned or in reset.
  always_comb begin
    o_available_item = '0;
    if (reset_n && state_q != ST_RETURN) begin
      for (int i = 0; i < kNumItems; i++) begin
        o_available_item[i] = current_total >= kTotalBits'(kItemPrice[i]);
      end
    end
  end

  // Next-state, next-total, timer and pulse decisions with event priority
  // return > coin > item; lower-priority events in the same cycle are dropped.
  always_comb begin
    state_nxt         = state_q;
    timer_nxt         = timer_q;
    current_total_nxt = current_total;
    output_item_nxt   = '0;
    return_coin_nxt   = '0;
    reload            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A return request with no credit is not an event, so a coin still counts.
        if (coin_valid) begin
          if (coin_overflow) begin
            return_coin_nxt = i_input_coin;
          end else begin
            current_total_nxt = coin_sum[kTotalBits-1:0];
            state_nxt         = ST_ACTIVE;
            timer_nxt         = kTimerBits'(kWaitTime);
          end
        end
      end

      ST_ACTIVE: begin
        if (i_trigger_return) begin
          state_nxt = ST_RETURN;
          timer_nxt = '0;
        end else begin
          if (coin_valid) begin
            if (coin_overflow) begin
              // Rejected coin goes straight back; it does not restart the timer.
              return_coin_nxt = i_input_coin;
            end else begin
              current_total_nxt = coin_sum[kTotalBits-1:0];
              reload            = 1'b1;
            end
          end else if (item_valid && item_affordable) begin
            current_total_nxt = current_total - item_price;
            output_item_nxt   = i_select_item;
            reload            = 1'b1;
          end

          if (reload) begin
            timer_nxt = kTimerBits'(kWaitTime);
          end else if (timer_q <= kTimerBits'(1)) begin
            state_nxt = ST_RETURN;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer_q - kTimerBits'(1);
          end
        end
      end

      ST_RETURN: begin
        if (current_total == '0) begin
          state_nxt = ST_IDLE;
        end else if (ret_onehot != '0) begin
          return_coin_nxt   = ret_onehot;
          current_total_nxt = current_total - ret_value;
        end else begin
          // A residue below the smallest coin cannot be paid out; drop it
          // rather than stall in RETURN forever.
          current_total_nxt = '0;
          state_nxt         = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    if (!reset_n) begin
      current_total_nxt = '0;
    end
  end

  // State, timer and output pulse registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      o_output_item <= '0;
      o_return_coin <= '0;
    end else begin
      state_q       <= state_nxt;
      timer_q       <= timer_nxt;
      o_output_item <= output_item_nxt;
      o_return_coin <= return_coin_nxt;
    end
  end

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// tb_vending_txn_ctrl: directed self-checking bench for vending_txn_ctrl.
// Models the downstream total register (with a preload port for the
// near-overflow case) and walks a linear sequence of hand-computed steps.
module tb_vending_txn_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic [30:0] current_total = '0;
  logic [30:0] current_total_nxt;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;

  logic        load_en  = 1'b0;
  logic [30:0] load_val = '0;

  int n_vec = 0;
  int n_err = 0;

  vending_txn_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_input_coin      (i_input_coin),
    .i_select_item     (i_select_item),
    .i_trigger_return  (i_trigger_return),
    .current_total     (current_total),
    .current_total_nxt (current_total_nxt),
    .o_available_item  (o_available_item),
    .o_output_item     (o_output_item),
    .o_return_coin     (o_return_coin)
  );

  always #5 clk = ~clk;

  // Downstream total register stage, with an optional preload.
  always @(posedge clk) begin
    current_total <= load_en ? load_val : current_total_nxt;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a new cycle: wait for the edge, drive inputs, let combinational settle.
  task automatic cycle(input logic rn, input logic [2:0] coin, input logic [3:0] item,
                       input logic trig);
    @(posedge clk);
    #1;
    reset_n          = rn;
    i_input_coin     = coin;
    i_select_item    = item;
    i_trigger_return = trig;
    #1;
  endtask

  initial begin
    reset_n          = 1'b0;
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;

    // Reset held three cycles with coins toggling.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, (i % 2 == 0) ? 3'b001 : 3'b100, 4'b0000, 1'b0);
      check("rst_nxt",   current_total_nxt, 0);
      check("rst_avail", o_available_item,  0);
      check("rst_item",  o_output_item,     0);
      check("rst_coin",  o_return_coin,     0);
    end
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("rel_total", current_total,     0);
    check("rel_nxt",   current_total_nxt, 0);

    // 500 + 500 + 100, then buy item 2 (1000).
    cycle(1'b1, 3'b010, 4'b0000, 1'b0);
    check("c500_nxt", current_total_nxt, 500);
    cycle(1'b1, 3'b010, 4'b0000, 1'b0);
    check("c500b_tot", current_total,     500);
    check("c500b_nxt", current_total_nxt, 1000);
    cycle(1'b1, 3'b001, 4'b0000, 1'b0);
    check("c100_nxt", current_total_nxt, 1100);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("t1100_tot",   current_total,    1100);
    check("t1100_avail", o_available_item, 4'b0111);
    cycle(1'b1, 3'b000, 4'b0100, 1'b0);
    check("buy2_nxt", current_total_nxt, 100);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("buy2_pulse", o_output_item,    4'b0100);
    check("buy2_tot",   current_total,    100);
    check("t100_avail", o_available_item, 4'b0000);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("buy2_once", o_output_item, 4'b0000);

    // Raise to 1600 and request change: 1000, 500, 100.
    cycle(1'b1, 3'b010, 4'b0000, 1'b0);
    cycle(1'b1, 3'b100, 4'b0000, 1'b0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("t1600_tot", current_total, 1600);
    cycle(1'b1, 3'b000, 4'b0000, 1'b1);
    check("trig_nxt", current_total_nxt, 1600);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("r1_coin",  o_return_coin,     0);
    check("r1_nxt",   current_total_nxt, 600);
    check("r1_avail", o_available_item,  0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("r2_coin", o_return_coin,     3'b100);
    check("r2_nxt",  current_total_nxt, 100);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("r3_coin", o_return_coin,     3'b010);
    check("r3_nxt",  current_total_nxt, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("r4_coin", o_return_coin, 3'b001);
    check("r4_tot",  current_total, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("r5_coin", o_return_coin, 0);

    // Insert 1000 at cycle 0 and idle: RETURN entered at the edge ending cycle 10.
    cycle(1'b1, 3'b100, 4'b0000, 1'b0);
    check("to_c1000_nxt", current_total_nxt, 1000);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 3'b000, 4'b0000, 1'b0);
      if (k == 5) check("to_avail", o_available_item, 4'b0111);
    end
    check("to_c10_coin", o_return_coin,     0);
    check("to_c10_nxt",  current_total_nxt, 1000);
    cycle(1'b1, 3'b001, 4'b0000, 1'b0);
    check("to_c11_nxt",   current_total_nxt, 0);
    check("to_c11_avail", o_available_item,  0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("to_c12_coin", o_return_coin, 3'b100);
    check("to_c12_tot",  current_total, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("to_c13_coin", o_return_coin, 0);
    check("to_c13_tot",  current_total, 0);

    // Priority: coin beats select; trigger beats coin.
    repeat (4) cycle(1'b1, 3'b001, 4'b0000, 1'b0);
    cycle(1'b1, 3'b001, 4'b0001, 1'b0);
    check("pri_tot400", current_total,     400);
    check("pri_cs_nxt", current_total_nxt, 500);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("pri_cs_item", o_output_item, 0);
    check("pri_cs_tot",  current_total, 500);
    cycle(1'b1, 3'b100, 4'b0000, 1'b1);
    check("pri_tc_nxt", current_total_nxt, 500);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("pri_r1_nxt", current_total_nxt, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("pri_r2_coin", o_return_coin, 3'b010);
    check("pri_r2_tot",  current_total, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("pri_r3_coin", o_return_coin, 0);

    // Near-overflow credit: a 1000 coin is rejected and bounced back.
    cycle(1'b1, 3'b001, 4'b0000, 1'b0);
    load_val = 31'd2147483600;
    load_en  = 1'b1;
    cycle(1'b1, 3'b100, 4'b0000, 1'b0);
    load_en = 1'b0;
    check("ovf_tot", current_total,     31'd2147483600);
    check("ovf_nxt", current_total_nxt, 31'd2147483600);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("ovf_coin",  o_return_coin,     3'b100);
    check("ovf_keep",  current_total_nxt, 31'd2147483600);
    check("ovf_avail", o_available_item,  4'b1111);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("ovf_once", o_return_coin, 0);

    // Reset mid-ACTIVE discards the credit.
    cycle(1'b0, 3'b000, 4'b0000, 1'b0);
    check("rsta_nxt",   current_total_nxt, 0);
    check("rsta_avail", o_available_item,  0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("rsta_tot",  current_total, 0);
    check("rsta_coin", o_return_coin, 0);

    // 300 credit, unaffordable select does not reload the timer.
    repeat (3) cycle(1'b1, 3'b001, 4'b0000, 1'b0);
    cycle(1'b1, 3'b000, 4'b0001, 1'b0);
    check("poor_nxt", current_total_nxt, 300);
    for (int k = 2; k <= 10; k++) cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_item", o_output_item,     0);
    check("poor_c10",  current_total_nxt, 300);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_c11_nxt", current_total_nxt, 200);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_c12_coin", o_return_coin, 3'b001);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_c13_coin", o_return_coin, 3'b001);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_c14_coin", o_return_coin, 3'b001);
    check("poor_c14_tot",  current_total, 0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("poor_c15_coin", o_return_coin, 0);

    // Reset mid-RETURN: no residual pulse, back to IDLE.
    cycle(1'b1, 3'b100, 4'b0000, 1'b0);
    cycle(1'b1, 3'b000, 4'b0000, 1'b1);
    cycle(1'b0, 3'b000, 4'b0000, 1'b0);
    check("rstr_nxt", current_total_nxt, 0);
    cycle(1'b1, 3'b010, 4'b0000, 1'b0);
    check("rstr_coin", o_return_coin,     0);
    check("rstr_tot",  current_total,     0);
    check("rstr_idle", current_total_nxt, 500);
    cycle(1'b1, 3'b000, 4'b0000, 1'b0);
    check("rstr_quiet", o_return_coin, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vending_txn_ctrl.md
# vending_txn_ctrl

Transaction controller for the vending machine datapath: decodes coin insertions, item selections and return requests, and computes `current_total_nxt` for the total-holding register stage directly downstream, which feeds `current_total` back one cycle later. It owns the inactivity timeout counter and the change-return state machine, and generates the registered item-dispense and coin-return pulses.

## Interface
- kTotalBits, 31, width of the running total
- kNumCoins, 3, coin types; values 100, 500, 1000 (index 0..2)
- kNumItems, 4, item types; prices 400, 500, 1000, 2000 (index 0..3)
- kWaitTime, 10, inactivity timeout in cycles
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- i_input_coin  in  kNumCoins  one-hot coin insertion, one cycle per coin
- i_select_item  in  kNumItems  one-hot item request
- i_trigger_return  in  1  user change-return request
- current_total  in  kTotalBits  registered total from downstream register stage
- current_total_nxt  out  kTotalBits  next total, combinational
- o_available_item  out  kNumItems  bit i = item i affordable, combinational
- o_output_item  out  kNumItems  registered one-cycle dispense pulse
- o_return_coin  out  kNumCoins  registered one-hot coin-return pulse

## Operation
- States: IDLE (total 0, no timer), ACTIVE (credit held, timer running), RETURN (dispensing change). Reset -> IDLE, timer 0, o_output_item 0, o_return_coin 0.
- Event priority per cycle, highest first: i_trigger_return, coin, item select; lower-priority events in the same cycle are dropped, not queued.
- Non-one-hot i_input_coin or i_select_item (0 or >1 bits) = no event.
- Coin (IDLE/ACTIVE): nxt = total + value; if result exceeds 2^kTotalBits-1 the coin is rejected (nxt = total) and immediately returned via o_return_coin the next cycle. Accepted coin: state -> ACTIVE, timer reloads to kWaitTime.
- Item select (ACTIVE): if total >= price: nxt = total - price, o_output_item bit pulses next cycle, timer reloads. Else ignored, no timer reload.
- Timer decrements by 1 each ACTIVE cycle without a reloading event; on reaching 0 or on i_trigger_return -> RETURN. Trigger in IDLE ignored.
- RETURN: each cycle selects largest coin value <= current_total, pulses that bit of o_return_coin next cycle, nxt = total - value. When current_total == 0 -> IDLE. All user inputs ignored in RETURN.
- Greedy return terminates for any total that is a multiple of 100; totals are always multiples of 100 by construction.
- o_available_item forced to 0 in RETURN and during reset.
- No event: nxt = current_total. During reset: nxt = 0.

## Timing
- Event in cycle N -> current_total_nxt changes in N (comb) -> current_total updated at edge ending N, visible in N+1.
- o_output_item / o_return_coin asserted exactly one cycle (N+1) per event, all-zero otherwise.
- RETURN drains one coin per cycle; decision in cycle N uses current_total of cycle N (already reflecting previous coin).
- Timeout: last reloading event at cycle N -> RETURN entered at edge ending N+kWaitTime.
- Reset asserted mid-RETURN or mid-ACTIVE: outputs 0 next cycle, state IDLE, no residual pulse; remaining credit discarded.

## Test plan
- Reset: hold reset_n=0 3 cycles with coins toggling -> all outputs 0, nxt 0, state IDLE.
- Insert 500, 500, 100 -> current_total 1100; o_available_item = 0b0111; select item 2 -> o_output_item = 0b0100 one cycle, total 100.
- Total 1600, i_trigger_return -> o_return_coin sequence 0b100, 0b010, 0b001 on consecutive cycles, total 0, IDLE.
- Insert 1000, idle kWaitTime cycles -> RETURN entered at cycle 10, single 0b100 pulse; coin inserted during RETURN ignored.
- Same cycle coin 100 + select item 0 at total 400 -> coin taken (500), no dispense; same cycle trigger + coin -> coin dropped, return of prior total.
- Total near 2^kTotalBits-1, insert 1000 -> rejected, o_return_coin = 0b100 next cycle, total unchanged; select with insufficient total (300, item 0) -> no pulse, timer keeps counting.
